fft_output_serializer: RTL and testbench

- Downstream consumer of the second radix-4 butterfly stage in the 16-point FFT datapath.
- Captures one full 16-point complex result frame of 16-bit re/im words in a single cycle.
- Optionally undoes the radix-4 digit-reversed output order and applies a rounded right-shift scale.
- Streams the frame out one complex sample per beat over a valid/ready handshake, with start- and end-of-frame markers and a sticky dropped-frame flag.

---
 rtl/fft_output_serializer.sv | 159 +++++++++++++++
 tb/tb_fft_output_serializer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_serializer.sv
// fft_output_serializer
//
// Captures one 16-point complex frame from the second radix-4 butterfly
// stage in a single cycle. It then streams the frame out one complex sample
// per beat over a valid/ready handshake. The digit-reversed butterfly order
// can optionally be undone, and each output component can be scaled by a
// rounded arithmetic right shift.
//
// Parameters:
//   W       sample width (signed two's complement) of re and im
//   N       points per frame (fixed at 16, 4-bit index)
//   REORDER 1: output k reads slot {k[1:0],k[3:2]}; 0: output k reads slot k
//   SHIFT   right shift 0..4 applied on output, rounded half-up
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   in_re, in_im      packed frame, slot i at [W*i +: W]
//   in_valid/in_ready frame capture handshake
//   out_re, out_im    scaled output sample
//   out_index         natural-order bin number k of the current sample
//   out_sop, out_eop  first (k=0) / last (k=15) beat markers
//   out_valid/out_ready output handshake
//   frame_dropped     sticky flag: a frame was offered while in_ready was low
//   clear_status      synchronous clear of frame_dropped (a new drop wins)

module fft_output_serializer #(
  parameter int W       = 16,
  parameter int N       = 16,
  parameter int REORDER = 1,
  parameter int SHIFT   = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_re,
  input  logic [N*W-1:0] in_im,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_re,
  output logic [W-1:0]   out_im,
  output logic [3:0]     out_index,
  output logic           out_sop,
  output logic           out_eop,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           frame_dropped,
  input  logic           clear_status
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Rounding constant 2^(SHIFT-1); evaluates to zero when SHIFT is 0.
  localparam logic signed [W:0] RND = (W+1)'((1 << SHIFT) >> 1);

  // Sign-extend by one bit so that adding the rounding constant cannot wrap.
  function automatic logic [W-1:0] scale(input logic [W-1:0] x);
    logic signed [W:0] t;
    t = $signed({x[W-1], x}) + RND;
    t = t >>> SHIFT;
    return t[W-1:0];
  endfunction

  logic [W-1:0] in_re_w [N];
  logic [W-1:0] in_im_w [N];
  logic [W-1:0] buf_re_q [N];
  logic [W-1:0] buf_im_q [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign in_re_w[gi] = in_re[W*gi +: W];
    assign in_im_w[gi] = in_im[W*gi +: W];
  end

  logic [0:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] out_re_q, out_re_d;
  logic [W-1:0] out_im_q, out_im_d;
  logic         frame_dropped_q, frame_dropped_d;

  logic         capture;
  logic         accept;
  logic [3:0]   nxt_k;
  logic [3:0]   rd_slot;

  assign out_valid     = (state_q == ST_STREAM);
  assign out_re        = out_re_q;
  assign out_im        = out_im_q;
  assign out_index     = cnt_q;
  assign out_sop       = out_valid & (cnt_q == 4'd0);
  assign out_eop       = out_valid & (cnt_q == 4'd15);
  assign frame_dropped = frame_dropped_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    out_re_d        = out_re_q;
    out_im_d        = out_im_q;
    frame_dropped_d = frame_dropped_q;

    // The final accepted beat frees the buffer, so a new frame can be taken
    // in that same cycle without a gap between frames.
    in_ready = (state_q == ST_IDLE) |
               ((state_q == ST_STREAM) & (cnt_q == 4'd15) & out_ready);
    capture  = in_valid & in_ready;
    accept   = out_valid & out_ready;

    nxt_k   = cnt_q + 4'd1;
    rd_slot = (REORDER != 0) ? {nxt_k[1:0], nxt_k[3:2]} : nxt_k;

    if (capture) begin
      // Bin 0 maps to slot 0 in either ordering. It is taken straight from the
      // input because the buffer write has not happened yet.
      state_d  = ST_STREAM;
      cnt_d    = 4'd0;
      out_re_d = scale(in_re_w[0]);
      out_im_d = scale(in_im_w[0]);
    end else if (accept) begin
      if (cnt_q == 4'd15) begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d    = nxt_k;
        out_re_d = scale(buf_re_q[rd_slot]);
        out_im_d = scale(buf_im_q[rd_slot]);
      end
    end

    if (in_valid & ~in_ready)
      frame_dropped_d = 1'b1;
    else if (clear_status)
      frame_dropped_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 4'd0;
      out_re_q        <= '0;
      out_im_q        <= '0;
      frame_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      out_re_q        <= out_re_d;
      out_im_q        <= out_im_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  // Frame buffer contents are don't-care after reset, so the buffer has no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        buf_re_q[i] <= in_re_w[i];
        buf_im_q[i] <= in_im_w[i];
      end
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
module tb_fft_output_serializer;

  localparam int W = 16;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic [N*W-1:0] in_re = '0;
  logic [N*W-1:0] in_im = '0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic           clear_status = 1'b0;

  // dut0: natural order, no scaling. dut1: reordered. dut2: natural order, SHIFT=2.
  logic         rdy0, rdy1, rdy2;
  logic [W-1:0] re0, im0, re1, im1, re2, im2;
  logic [3:0]   idx0, idx1, idx2;
  logic         sop0, sop1, sop2, eop0, eop1, eop2;
  logic         val0, val1, val2, drop0, drop1, drop2;

  int n_cmp = 0;
  int n_bad = 0;

  fft_output_serializer #(.W(W), .N(N), .REORDER(0), .SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_ready(rdy0), .out_re(re0), .out_im(im0), .out_index(idx0), .out_sop(sop0),
    .out_eop(eop0), .out_valid(val0), .out_ready(out_ready), .frame_dropped(drop0),
    .clear_status(clear_status));

  fft_output_serializer #(.W(W), .N(N), .REORDER(1), .SHIFT(0)) dut1 (
    .clk(clk), .reset(reset), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_ready(rdy1), .out_re(re1), .out_im(im1), .out_index(idx1), .out_sop(sop1),
    .out_eop(eop1), .out_valid(val1), .out_ready(out_ready), .frame_dropped(drop1),
    .clear_status(clear_status));

  fft_output_serializer #(.W(W), .N(N), .REORDER(0), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_ready(rdy2), .out_re(re2), .out_im(im2), .out_index(idx2), .out_sop(sop2),
    .out_eop(eop2), .out_valid(val2), .out_ready(out_ready), .frame_dropped(drop2),
    .clear_status(clear_status));

  task automatic set_slot(input int i, input logic [W-1:0] r, input logic [W-1:0] m);
    in_re[W*i +: W] = r;
    in_im[W*i +: W] = m;
  endtask

  // Called at a negedge; returns at the next negedge, with beat 0 visible.
  task automatic send_frame();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({val0, re0, im0, idx0, sop0, eop0, drop0} !== {1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b re=%h im=%h k=%0d sop=%b eop=%b drop=%b, expected all zero",
               val0, re0, im0, idx0, sop0, eop0, drop0);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rdy0, val0} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", rdy0, val0);
    end
  endtask

  task automatic test_natural();
    logic [38:0] exp_v;
    for (int i = 0; i < N; i++) set_slot(i, 16'(i), 16'(-i));
    out_ready = 1'b1;
    n_cmp++;
    if (val0 !== 1'b0) begin
      n_bad++;
      $display("FAIL nat_idle: got out_valid=%b expected 0", val0);
    end
    send_frame();
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, 16'(k), 16'(-k), 4'(k), (k == 0), (k == 15)};
      n_cmp++;
      if ({val0, re0, im0, idx0, sop0, eop0} !== exp_v) begin
        n_bad++;
        $display("FAIL nat_beat k=%0d: got v=%b re=%h im=%h k=%0d sop=%b eop=%b expected %h",
                 k, val0, re0, im0, idx0, sop0, eop0, exp_v);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({val0, rdy0} !== 2'b01) begin
      n_bad++;
      $display("FAIL nat_end: got out_valid=%b in_ready=%b expected 0 1", val0, rdy0);
    end
  endtask

  task automatic test_reorder();
    logic [3:0]  kk;
    logic [W-1:0] exp_re;
    for (int i = 0; i < N; i++) set_slot(i, 16'h0100 + 16'(i), 16'(i));
    send_frame();
    for (int k = 0; k < 16; k++) begin
      kk = 4'(k);
      exp_re = 16'h0100 | {12'd0, kk[1:0], kk[3:2]};
      n_cmp++;
      if ({val1, re1, im1, idx1} !== {1'b1, exp_re, exp_re - 16'h0100, kk}) begin
        n_bad++;
        $display("FAIL reorder_beat k=%0d: got v=%b re=%h im=%h k=%0d expected re=%h k=%0d",
                 k, val1, re1, im1, idx1, exp_re, kk);
      end
      n_cmp++;
      if (re0 !== 16'h0100 + 16'(k)) begin
        n_bad++;
        $display("FAIL natural_order_beat k=%0d: got re=%h expected %h", k, re0, 16'h0100 + 16'(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] exp_re_t [3];
    logic [W-1:0] exp_im_t [3];
    exp_re_t = '{16'h0002, 16'hFFFF, 16'h2000};
    exp_im_t = '{16'h0000, 16'h0001, 16'h0000};
    for (int i = 0; i < N; i++) set_slot(i, 16'h0000, 16'h0000);
    set_slot(0, 16'h0006, 16'h0001);
    set_slot(1, 16'hFFFA, 16'h0002);
    set_slot(2, 16'h7FFF, 16'hFFFE);
    send_frame();
    for (int k = 0; k < 16; k++) begin
      if (k < 3) begin
        n_cmp++;
        if ({val2, re2, im2} !== {1'b1, exp_re_t[k], exp_im_t[k]}) begin
          n_bad++;
          $display("FAIL shift_beat k=%0d: got v=%b re=%h im=%h expected re=%h im=%h",
                   k, val2, re2, im2, exp_re_t[k], exp_im_t[k]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int got;
    got = 0;
    for (int i = 0; i < N; i++) set_slot(i, 16'h0020 + 16'(i), 16'h0040 + 16'(i));
    out_ready = 1'b1;
    send_frame();
    for (int c = 0; c < 80 && got < 16; c++) begin
      // Whether or not the previous beat was accepted, the outputs must show
      // the oldest sample not yet accepted.
      n_cmp++;
      if ({val0, re0, im0, idx0} !== {1'b1, 16'h0020 + 16'(got), 16'h0040 + 16'(got), 4'(got)}) begin
        n_bad++;
        $display("FAIL bp_sample c=%0d: got v=%b re=%h im=%h k=%0d expected sample %0d",
                 c, val0, re0, im0, idx0, got);
      end
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (out_ready) got++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_cmp++;
    if ({got == 16, val0} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_count: got %0d samples out_valid=%b expected 16 0", got, val0);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < N; i++) set_slot(i, 16'(i), 16'h0000);
    out_ready = 1'b1;
    send_frame();
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({val0, re0, idx0} !== {1'b1, 16'(k), 4'(k)}) begin
        n_bad++;
        $display("FAIL drop_stream k=%0d: got v=%b re=%h k=%0d expected re=%h", k, val0, re0, idx0, 16'(k));
      end
      if (k == 5) begin
        n_cmp++;
        if (drop0 !== 1'b0) begin
          n_bad++;
          $display("FAIL drop_before: got %b expected 0", drop0);
        end
        set_slot(0, 16'h7777, 16'h7777);
        in_valid = 1'b1;
      end
      if (k == 6) begin
        in_valid = 1'b0;
        n_cmp++;
        if (drop0 !== 1'b1) begin
          n_bad++;
          $display("FAIL drop_set: got %b expected 1", drop0);
        end
      end
      if (k == 8) begin
        in_valid = 1'b1;
        clear_status = 1'b1;
      end
      if (k == 9) begin
        in_valid = 1'b0;
        clear_status = 1'b0;
        n_cmp++;
        if (drop0 !== 1'b1) begin
          n_bad++;
          $display("FAIL drop_wins_clear: got %b expected 1", drop0);
        end
      end
      if (k == 10) clear_status = 1'b1;
      if (k == 11) begin
        clear_status = 1'b0;
        n_cmp++;
        if (drop0 !== 1'b0) begin
          n_bad++;
          $display("FAIL drop_clear: got %b expected 0", drop0);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (val0 !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_end: got out_valid=%b expected 0", val0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) set_slot(i, 16'(i), 16'h0000);
    out_ready = 1'b1;
    send_frame();
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({val0, re0, eop0} !== {1'b1, 16'(k), (k == 15)}) begin
        n_bad++;
        $display("FAIL b2b_first k=%0d: got v=%b re=%h eop=%b", k, val0, re0, eop0);
      end
      if (k == 15) begin
        for (int i = 0; i < N; i++) set_slot(i, 16'h0050 + 16'(i), 16'h0000);
        in_valid = 1'b1;
        n_cmp++;
        if (rdy0 !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ready: got in_ready=%b expected 1", rdy0);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({val0, re0, idx0, sop0, eop0} !== {1'b1, 16'h0050 + 16'(k), 4'(k), (k == 0), (k == 15)}) begin
        n_bad++;
        $display("FAIL b2b_second k=%0d: got v=%b re=%h k=%0d sop=%b eop=%b expected re=%h",
                 k, val0, re0, idx0, sop0, eop0, 16'h0050 + 16'(k));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (val0 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: got out_valid=%b expected 0", val0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) set_slot(i, 16'(i), 16'h0000);
    out_ready = 1'b1;
    send_frame();
    repeat (7) @(negedge clk);
    n_cmp++;
    if ({val0, idx0} !== {1'b1, 4'd7}) begin
      n_bad++;
      $display("FAIL rstmid_pre: got v=%b k=%0d expected 1 7", val0, idx0);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({val0, idx0, re0} !== {1'b0, 4'd0, 16'h0}) begin
      n_bad++;
      $display("FAIL rstmid_async: got v=%b k=%0d re=%h expected 0 0 0000", val0, idx0, re0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rdy0, val0} !== 2'b10) begin
      n_bad++;
      $display("FAIL rstmid_release: got in_ready=%b out_valid=%b expected 1 0", rdy0, val0);
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_reorder();
    test_shift();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
